// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: round-robin owner of the single framebuffer write port.
// Up to N_REQ requesters each get a burst of at most MAX_BURST beats; the
// winning beat is registered toward the framebuffer RAM one cycle after ack.
// Optional build macro VBLANK_GATE_EN: when defined, beats are accepted only
// while vblank is high (the owner keeps the grant and its count stalls).
module fb_write_arbiter #(
    parameter int N_REQ     = 12,
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16,
    parameter int FB_DEPTH  = 307200
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic                      vblank,
    output logic [N_REQ-1:0]          grant,
    output logic [N_REQ-1:0]          ack,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    output logic                      oob_err
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [ADDR_W:0]    FB_LIMIT  = (ADDR_W+1)'(FB_DEPTH);
    localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [PTR_W-1:0]   PTR_INIT  = PTR_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0]   ONE_HOT0  = N_REQ'(1);

    typedef enum logic {ST_IDLE, ST_BURST} state_t;

    state_t              state_q;
    logic [N_REQ-1:0]    grant_q;
    logic [PTR_W-1:0]    ptr_q;      // last winner; doubles as owner index in BURST
    logic [CNT_W-1:0]    cnt_q;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic                oob_q;

    logic                arb_vld_d;
    logic [PTR_W-1:0]    arb_idx_d;
    logic [PTR_W-1:0]    scan_idx;

    logic [ADDR_W-1:0]   addr_arr [N_REQ];
    logic [DATA_W-1:0]   data_arr [N_REQ];

    logic                beat_en;
    logic                owner_req;
    logic                beat;
    logic                addr_ok;

    // Unflatten the requester buses so the owner can be picked by index.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
            assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

`ifdef VBLANK_GATE_EN
    assign beat_en = vblank;
`else
    // vblank has no effect here; OR-ing keeps the port referenced.
    assign beat_en = vblank | 1'b1;
`endif

    assign owner_req = req[ptr_q];
    assign beat      = (state_q == ST_BURST) && owner_req && beat_en;
    assign addr_ok   = ({1'b0, addr_arr[ptr_q]} < FB_LIMIT);

    // grant_q is one-hot at the owner, so masking it gives the one-hot ack.
    assign ack = beat ? grant_q : '0;

    // Round-robin search: first request strictly after the last winner.
    always_comb begin
        arb_vld_d = 1'b0;
        arb_idx_d = ptr_q;
        scan_idx  = ptr_q;
        for (int off = 1; off <= N_REQ; off++) begin
            scan_idx = PTR_W'((int'(ptr_q) + off) % N_REQ);
            if (!arb_vld_d && req[scan_idx]) begin
                arb_vld_d = 1'b1;
                arb_idx_d = scan_idx;
            end
        end
    end

    // Arbitration FSM plus registered write path and sticky range error.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            ptr_q     <= PTR_INIT;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            oob_q     <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (arb_vld_d) begin
                        grant_q <= ONE_HOT0 << arb_idx_d;
                        ptr_q   <= arb_idx_d;
                        cnt_q   <= '0;
                        state_q <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (beat) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (addr_ok) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= addr_arr[ptr_q];
                            wr_data_q <= data_arr[ptr_q];
                        end else begin
                            oob_q <= 1'b1;
                        end
                    end
                    // Release on a dropped request or after the last allowed beat.
                    if (!owner_req || (beat && (cnt_q == LAST_BEAT))) begin
                        grant_q <= '0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    grant_q <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant   = grant_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign oob_err = oob_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb_fb_write_arbiter: cycle model of the arbiter plus per-requester beat
// sources; accepted beats are queued and compared against the write port.
module tb_fb_write_arbiter;

    localparam int N   = 12;
    localparam int AW  = 19;
    localparam int DW  = 8;
    localparam int MB  = 16;
    localparam int FBD = 307200;

    logic              clock = 1'b0;
    logic              resetn = 1'b0;
    logic [N-1:0]      req;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic              vblank;
    logic [N-1:0]      grant;
    logic [N-1:0]      ack;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              oob_err;

    fb_write_arbiter #(
        .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB), .FB_DEPTH(FBD)
    ) dut (
        .clock(clock), .resetn(resetn), .req(req), .req_addr(req_addr),
        .req_data(req_data), .vblank(vblank), .grant(grant), .ack(ack),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .oob_err(oob_err)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // requester sources: rem = beats left (-1 = endless)
    int          rem      [N];
    int          r_addr   [N];
    logic [7:0]  r_data   [N];
    int          jump_addr[N];
    bit          jump_en  [N];

    // reference arbiter state
    bit          m_busy;
    int          m_owner;
    int          m_ptr;
    int          m_cnt;
    logic [N-1:0] m_grant;
    bit          m_oob;

    typedef struct {
        bit            ok;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;
    wr_t sb[$];

    int ack_cnt[N];
    int wr_cnt;
    int run2;
    int max_run2;

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req[i] = (rem[i] != 0);
            req_addr[i*AW +: AW] = AW'(r_addr[i]);
            req_data[i*DW +: DW] = r_data[i];
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_ptr = N - 1; m_cnt = 0; m_grant = '0; m_oob = 0;
        sb.delete();
    endtask

    task automatic clear_stats();
        for (int i = 0; i < N; i++) ack_cnt[i] = 0;
        wr_cnt = 0; run2 = 0; max_run2 = 0;
    endtask

    task automatic step();
        logic [N-1:0] exp_ack;
        logic [N-1:0] req_now;
        logic [N-1:0] one;
        bit  ben;
        bit  beat;
        bit  found;
        int  o;
        int  idx;
        wr_t it;
        one = 1;
        @(negedge clock);
`ifdef VBLANK_GATE_EN
        ben = vblank;
`else
        ben = 1'b1;
`endif
        exp_ack = '0;
        if (m_busy && req[m_owner] && ben) exp_ack[m_owner] = 1'b1;
        check("grant", grant, m_grant);
        check("ack", ack, exp_ack);
        check("oob_err", oob_err, m_oob);
        for (int i = 0; i < N; i++) ack_cnt[i] += int'(ack[i]);
        if (ack[2]) run2++; else run2 = 0;
        if (run2 > max_run2) max_run2 = run2;
        beat = resetn && (exp_ack != '0);
        o = m_owner;
        if (beat) begin
            it.ok   = (r_addr[o] < FBD);
            it.addr = AW'(r_addr[o]);
            it.data = r_data[o];
            sb.push_back(it);
        end
        req_now = req;
        @(posedge clock);
        #1;
        if (!resetn) begin
            model_reset();
            check("rst_wr_en", wr_en, 0);
            check("rst_wr_addr", wr_addr, 0);
            check("rst_wr_data", wr_data, 0);
        end else begin
            if (wr_en) wr_cnt++;
            if (beat) begin
                it = sb.pop_front();
                check("wr_en", wr_en, it.ok);
                if (it.ok) begin
                    check("wr_addr", wr_addr, it.addr);
                    check("wr_data", wr_data, it.data);
                end else begin
                    m_oob = 1;
                end
            end else begin
                check("wr_en_idle", wr_en, 0);
            end
            if (!m_busy) begin
                found = 0;
                for (int off = 1; off <= N; off++) begin
                    idx = (m_ptr + off) % N;
                    if (!found && req_now[idx]) begin
                        found = 1; m_busy = 1; m_owner = idx; m_ptr = idx;
                        m_cnt = 0; m_grant = one << idx;
                    end
                end
            end else if (!req_now[o]) begin
                m_busy = 0; m_grant = '0;
            end else if (beat) begin
                m_cnt++;
                if (m_cnt == MB) begin m_busy = 0; m_grant = '0; end
            end
            if (beat) begin
                if (rem[o] > 0) rem[o]--;
                if (jump_en[o]) begin r_addr[o] = jump_addr[o]; jump_en[o] = 0; end
                else r_addr[o]++;
            end
        end
        drive();
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) rem[i] = 0;
        drive();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            rem[i] = 0; r_addr[i] = 0; r_data[i] = '0; jump_addr[i] = 0; jump_en[i] = 0;
        end
`ifdef VBLANK_GATE_EN
        vblank = 1'b1;
`else
        vblank = 1'b0;   // ignored in this build
`endif
        resetn = 1'b0;
        drive();
        model_reset();
        clear_stats();
        step();
        step();
        resetn = 1'b1;

        // 1: single requester, four beats
        clear_stats();
        r_addr[3] = 100; r_data[3] = 8'hE0; rem[3] = 4; drive();
        step();
        check("t1_grant", grant, 12'h008);
        repeat (7) step();
        check("t1_acks", ack_cnt[3], 4);
        check("t1_writes", wr_cnt, 4);
        check("t1_idle", grant, 0);
        $display("t1 single burst acks=%0d writes=%0d", ack_cnt[3], wr_cnt);

        // 2: two requesters, two beats each
        do_reset(); clear_stats();
        rem[0] = 2; r_addr[0] = 200; r_data[0] = 8'h11;
        rem[5] = 2; r_addr[5] = 300; r_data[5] = 8'h55; drive();
        repeat (10) step();
        check("t2_acks0", ack_cnt[0], 2);
        check("t2_acks5", ack_cnt[5], 2);
        check("t2_writes", wr_cnt, 4);
        $display("t2 two owners acks0=%0d acks5=%0d", ack_cnt[0], ack_cnt[5]);

        // 3: forced release after MAX_BURST beats
        do_reset(); clear_stats();
        rem[2] = -1; r_addr[2] = 1000; r_data[2] = 8'h22;
        rem[7] = 3;  r_addr[7] = 2000; r_data[7] = 8'h77; drive();
        repeat (30) step();
        check("t3_max_run", max_run2, MB);
        check("t3_acks7", ack_cnt[7], 3);
        check("t3_regrant", ack_cnt[2] > MB, 1);
        $display("t3 forced release run=%0d acks2=%0d acks7=%0d", max_run2, ack_cnt[2], ack_cnt[7]);

        // 4: out-of-range beat then in-range beat
        do_reset(); clear_stats();
        rem[1] = 2; r_addr[1] = FBD; r_data[1] = 8'h3C; jump_addr[1] = 5; jump_en[1] = 1; drive();
        repeat (5) step();
        check("t4_acks", ack_cnt[1], 2);
        check("t4_writes", wr_cnt, 1);
        check("t4_oob", oob_err, 1);
        $display("t4 oob acks=%0d writes=%0d oob=%0b", ack_cnt[1], wr_cnt, oob_err);

        // 5: reset mid-burst (oob_err still set from 4)
        clear_stats();
        rem[6] = -1; r_addr[6] = 50; r_data[6] = 8'h66; drive();
        repeat (3) step();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        rem[6] = 0; drive();
        check("t5_writes", wr_cnt, 2);
        check("t5_grant", grant, 0);
        check("t5_oob_clr", oob_err, 0);
        rem[0] = 1; r_addr[0] = 10; rem[11] = 1; r_addr[11] = 20; drive();
        step();
        check("t5_first", grant, 12'h001);
        repeat (6) step();
        check("t5_acks11", ack_cnt[11], 1);
        $display("t5 reset mid-burst acks0=%0d acks11=%0d", ack_cnt[0], ack_cnt[11]);

`ifdef VBLANK_GATE_EN
        // 6: beats gated by vblank
        do_reset(); clear_stats();
        vblank = 1'b0;
        rem[4] = 3; r_addr[4] = 400; r_data[4] = 8'h44; drive();
        step();
        repeat (5) step();
        check("t6_grant", grant, 12'h010);
        check("t6_no_acks", ack_cnt[4], 0);
        check("t6_no_wr", wr_cnt, 0);
        vblank = 1'b1; drive();
        step();
        check("t6_first_ack", ack_cnt[4], 1);
        repeat (5) step();
        check("t6_acks", ack_cnt[4], 3);
        $display("t6 vblank gate acks=%0d writes=%0d", ack_cnt[4], wr_cnt);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
